// File: rtl/imem_loader.sv
// Instruction-memory loader: parses framed program images from a host byte stream,
// writes them into instruction memory and holds the core in reset until a verified image is present.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [7:0]       len_q, len_next;
    logic [7:0]       count, count_next;
    logic [7:0]       sum, sum_next;
    logic [TMO_W-1:0] tmo, tmo_next;
    logic             write_next;
    logic             accept;
    logic             timed_out;
    logic [7:0]       csum_total;

    assign accept     = in_valid && in_ready;
    assign timed_out  = (tmo == TMO_W'(TIMEOUT - 1));
    assign csum_total = sum + in_data;

    // NOTE: every variable driven here gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        len_next   = len_q;
        count_next = count;
        sum_next   = sum;
        tmo_next   = '0;
        write_next = 1'b0;

        case (state)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_next = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        state_next = ERR;
                    end else begin
                        len_next   = in_data;
                        count_next = 8'd0;
                        sum_next   = 8'd0;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    write_next = 1'b1;
                    count_next = count + 8'd1;
                    sum_next   = csum_total;
                    if (count == len_q - 8'd1) state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) state_next = (csum_total == 8'd0) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (accept && in_data == SYNC_BYTE) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase

        // A stalled host inside a frame aborts it; the counter stays idle outside frames.
        if (state == LEN || state == DATA || state == CSUM) begin
            if (accept) begin
                tmo_next = '0;
            end else if (timed_out) begin
                state_next = ERR;
                tmo_next   = '0;
            end else begin
                tmo_next = tmo + TMO_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= 8'd0;
            count      <= 8'd0;
            sum        <= 8'd0;
            tmo        <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 8'd0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_next;
            len_q     <= len_next;
            count     <= count_next;
            sum       <= sum_next;
            tmo       <= tmo_next;
            in_ready  <= 1'b1;
            imem_we   <= write_next;
            if (write_next) begin
                imem_addr  <= ADDR_W'(count);
                imem_wdata <= in_data;
            end
            // Status flags follow the next state so cpu_reset rises on the edge leaving DONE.
            cpu_reset <= (state_next != DONE);
            load_done <= (state_next == DONE);
            load_err  <= (state_next == ERR);
        end
    end

endmodule
